// File: rtl/ali_dmod.sv
// +----------------------------------------------------------------------------+
// | Module      : ali_dmod                                                      |
// | Description : AXI-Lite control block with one ID register and four RW CFG   |
// |               registers, behind an independent write/read slave FSM pair.   |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module ali_dmod_control_s_axi #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    s_axi_control_awvalid,
    output logic                    s_axi_control_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                    s_axi_control_wvalid,
    output logic                    s_axi_control_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                    s_axi_control_bvalid,
    input  logic                    s_axi_control_bready,
    output logic [1:0]              s_axi_control_bresp,
    input  logic                    s_axi_control_arvalid,
    output logic                    s_axi_control_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                    s_axi_control_rvalid,
    input  logic                    s_axi_control_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]              s_axi_control_rresp
);

    localparam logic [1:0]  WR_IDLE = 2'd0;
    localparam logic [1:0]  WR_DATA = 2'd1;
    localparam logic [1:0]  WR_RESP = 2'd2;
    localparam logic [1:0]  WR_RST  = 2'd3;
    localparam logic [0:0]  RD_IDLE = 1'b0;
    localparam logic [0:0]  RD_DATA = 1'b1;
    localparam logic [31:0] c_id    = 32'hA11D_0D01;

    logic [1:0]            wstate;
    logic [1:0]            w_wstate_nxt;
    logic [0:0]            r_rstate;
    logic [0:0]            w_rstate_nxt;
    logic                  r_ar_en;
    logic [ADDR_WIDTH-1:2] r_awaddr;
    logic [31:0]           r_cfg [0:3];
    logic [31:0]           r_rdata;
    logic [31:0]           w_rd_value;
    logic                  w_awready;
    logic                  w_wready;
    logic                  w_bvalid;
    logic                  w_arready;
    logic                  w_rvalid;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_unused;

    assign w_aw_hs  = s_axi_control_awvalid & w_awready;
    assign w_w_hs   = s_axi_control_wvalid & w_wready;
    assign w_ar_hs  = s_axi_control_arvalid & w_arready;
    assign w_unused = &{1'b0, s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0]};

    // ---------------- write FSM ----------------
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) wstate <= WR_RST;
        else           wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = wstate;
        case (wstate)
            WR_RST:  w_wstate_nxt = WR_IDLE;
            WR_IDLE: if (w_aw_hs) w_wstate_nxt = WR_DATA;
            WR_DATA: if (w_w_hs)  w_wstate_nxt = WR_RESP;
            WR_RESP: if (s_axi_control_bready) w_wstate_nxt = WR_IDLE;
            default: w_wstate_nxt = WR_RST;
        endcase
    end

    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (wstate)
            WR_IDLE: w_awready = 1'b1;
            WR_DATA: w_wready  = 1'b1;
            WR_RESP: w_bvalid  = 1'b1;
            default: ;
        endcase
    end

    // Register file; only CFG0..CFG3 (0x010..0x01C) are writable.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_awaddr <= '0;
            for (int i = 0; i < 4; i++) r_cfg[i] <= '0;
        end else begin
            if (w_aw_hs) r_awaddr <= s_axi_control_awaddr[ADDR_WIDTH-1:2];
            if (w_w_hs && r_awaddr[11:4] == 8'h01) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_axi_control_wstrb[b])
                        r_cfg[r_awaddr[3:2]][8*b +: 8] <= s_axi_control_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_rstate <= RD_IDLE;
            r_ar_en  <= 1'b0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_ar_en  <= 1'b1;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            RD_IDLE: if (w_ar_hs) w_rstate_nxt = RD_DATA;
            RD_DATA: if (s_axi_control_rready) w_rstate_nxt = RD_IDLE;
            default: w_rstate_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_rstate)
            RD_IDLE: w_arready = r_ar_en;
            RD_DATA: w_rvalid  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_rd_value = 32'h0;
        if (s_axi_control_araddr[11:2] == 10'h000)
            w_rd_value = c_id;
        else if (s_axi_control_araddr[11:4] == 8'h01)
            w_rd_value = r_cfg[s_axi_control_araddr[3:2]];
    end

    // Captured from the pre-edge register value, so a same-cycle write is not seen.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)    r_rdata <= '0;
        else if (w_ar_hs) r_rdata <= w_rd_value;
    end

    assign s_axi_control_awready = w_awready;
    assign s_axi_control_wready  = w_wready;
    assign s_axi_control_bvalid  = w_bvalid;
    assign s_axi_control_bresp   = 2'b00;
    assign s_axi_control_arready = w_arready;
    assign s_axi_control_rvalid  = w_rvalid;
    assign s_axi_control_rdata   = r_rdata;
    assign s_axi_control_rresp   = 2'b00;

endmodule

module ali_dmod #(
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
    parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32,
    parameter int C_OUT_TDATA_WIDTH          = 64,
    parameter int C_IN_TDATA_WIDTH           = 64,
    parameter int C_TUSER_WIDTH              = 8
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst_n,
    input  logic                                    s_axi_control_awvalid,
    output logic                                    s_axi_control_awready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                                    s_axi_control_wvalid,
    output logic                                    s_axi_control_wready,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                                    s_axi_control_bvalid,
    input  logic                                    s_axi_control_bready,
    output logic [1:0]                              s_axi_control_bresp,
    input  logic                                    s_axi_control_arvalid,
    output logic                                    s_axi_control_arready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                                    s_axi_control_rvalid,
    input  logic                                    s_axi_control_rready,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                              s_axi_control_rresp
);

    // Stream widths are placeholders for future ports; nothing is built from them yet.
    if (C_OUT_TDATA_WIDTH + C_IN_TDATA_WIDTH + C_TUSER_WIDTH < 0) begin : g_stream_reserved
    end

    ali_dmod_control_s_axi #(
        .ADDR_WIDTH (C_S_AXI_CONTROL_ADDR_WIDTH),
        .DATA_WIDTH (C_S_AXI_CONTROL_DATA_WIDTH)
    ) inst_control_s_axi (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .s_axi_control_awvalid (s_axi_control_awvalid),
        .s_axi_control_awready (s_axi_control_awready),
        .s_axi_control_awaddr  (s_axi_control_awaddr),
        .s_axi_control_wvalid  (s_axi_control_wvalid),
        .s_axi_control_wready  (s_axi_control_wready),
        .s_axi_control_wdata   (s_axi_control_wdata),
        .s_axi_control_wstrb   (s_axi_control_wstrb),
        .s_axi_control_bvalid  (s_axi_control_bvalid),
        .s_axi_control_bready  (s_axi_control_bready),
        .s_axi_control_bresp   (s_axi_control_bresp),
        .s_axi_control_arvalid (s_axi_control_arvalid),
        .s_axi_control_arready (s_axi_control_arready),
        .s_axi_control_araddr  (s_axi_control_araddr),
        .s_axi_control_rvalid  (s_axi_control_rvalid),
        .s_axi_control_rready  (s_axi_control_rready),
        .s_axi_control_rdata   (s_axi_control_rdata),
        .s_axi_control_rresp   (s_axi_control_rresp)
    );

endmodule

`default_nettype wire

// File: tb/tb_ali_dmod.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_ali_dmod                                                   |
// | Description : Directed self-checking bench for the ali_dmod AXI-Lite block. |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ali_dmod;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] rd_val;
    logic [1:0]  rd_resp;

    always #5 ap_clk = ~ap_clk;

    ali_dmod dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .s_axi_control_awvalid (awvalid),
        .s_axi_control_awready (awready),
        .s_axi_control_awaddr  (awaddr),
        .s_axi_control_wvalid  (wvalid),
        .s_axi_control_wready  (wready),
        .s_axi_control_wdata   (wdata),
        .s_axi_control_wstrb   (wstrb),
        .s_axi_control_bvalid  (bvalid),
        .s_axi_control_bready  (bready),
        .s_axi_control_bresp   (bresp),
        .s_axi_control_arvalid (arvalid),
        .s_axi_control_arready (arready),
        .s_axi_control_araddr  (araddr),
        .s_axi_control_rvalid  (rvalid),
        .s_axi_control_rready  (rready),
        .s_axi_control_rdata   (rdata),
        .s_axi_control_rresp   (rresp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_sig(input string tag, ref logic sig);
        int n = 0;
        while (sig !== 1'b1 && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        if (sig !== 1'b1) check({tag, "_timeout"}, 32'(sig), 32'd1);
    endtask

    // AW then W; B response held off for hold cycles while checking it stays pending.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int hold);
        @(negedge ap_clk);
        awvalid = 1'b1; awaddr = a;
        wait_sig("awready", awready);
        @(negedge ap_clk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = d; wstrb = s;
        wait_sig("wready", wready);
        @(negedge ap_clk);
        wvalid = 1'b0;
        wait_sig("bvalid", bvalid);
        check("bresp", 32'(bresp), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge ap_clk);
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("wstate_resp", 32'(dut.inst_control_s_axi.wstate), 32'd2);
        end
        bready = 1'b1;
        @(negedge ap_clk);
        bready = 1'b0;
        if (hold > 0) check("wstate_idle", 32'(dut.inst_control_s_axi.wstate), 32'd0);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
        @(negedge ap_clk);
        arvalid = 1'b1; araddr = a;
        wait_sig("arready", arready);
        @(negedge ap_clk);
        arvalid = 1'b0;
        wait_sig("rvalid", rvalid);
        d = rdata; r = rresp;
        rready = 1'b1;
        @(negedge ap_clk);
        rready = 1'b0;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;

        repeat (200) @(negedge ap_clk);
        check("rst_wstate", 32'(dut.inst_control_s_axi.wstate), 32'd3);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);

        ap_rst_n = 1'b1;
        #1;
        check("rel_awready", 32'(awready), 32'd0);
        check("rel_arready", 32'(arready), 32'd0);
        @(negedge ap_clk);
        check("idle_awready", 32'(awready), 32'd1);
        check("idle_arready", 32'(arready), 32'd1);
        check("idle_wready", 32'(wready), 32'd0);
        repeat (99) @(negedge ap_clk);

        axi_write(12'h010, 32'h1234_5678, 4'hF, 0);
        axi_read(12'h010, rd_val, rd_resp);
        check("cfg0_rdata", rd_val, 32'h1234_5678);
        check("cfg0_rresp", 32'(rd_resp), 32'd0);
        check("cfg0_rdata_hold", rdata, 32'h1234_5678);

        axi_read(12'h000, rd_val, rd_resp);
        check("id_rdata", rd_val, 32'hA11D_0D01);
        axi_write(12'h000, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(12'h000, rd_val, rd_resp);
        check("id_ro_rdata", rd_val, 32'hA11D_0D01);

        axi_write(12'h014, 32'hAABB_CCDD, 4'hF, 0);
        axi_write(12'h014, 32'h1122_3344, 4'b0101, 0);
        axi_read(12'h014, rd_val, rd_resp);
        check("cfg1_strb", rd_val, 32'hAA22_CC44);

        axi_write(12'h01C, 32'hCAFE_F00D, 4'hF, 5);
        axi_read(12'h01F, rd_val, rd_resp);
        check("cfg3_lowbits_ign", rd_val, 32'hCAFE_F00D);

        // Concurrent write and read of CFG2: read must see the old value.
        axi_write(12'h018, 32'h0000_0055, 4'hF, 0);
        @(negedge ap_clk);
        awvalid = 1'b1; awaddr = 12'h018;
        @(negedge ap_clk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h0000_0066; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 12'h018;
        check("conc_wready", 32'(wready), 32'd1);
        check("conc_arready", 32'(arready), 32'd1);
        @(negedge ap_clk);
        wvalid = 1'b0; arvalid = 1'b0;
        check("conc_bvalid", 32'(bvalid), 32'd1);
        check("conc_rvalid", 32'(rvalid), 32'd1);
        check("conc_old_val", rdata, 32'h0000_0055);
        bready = 1'b1; rready = 1'b1;
        @(negedge ap_clk);
        bready = 1'b0; rready = 1'b0;
        axi_read(12'h018, rd_val, rd_resp);
        check("conc_new_val", rd_val, 32'h0000_0066);

        axi_read(12'h100, rd_val, rd_resp);
        check("unmapped_rdata", rd_val, 32'd0);
        check("unmapped_rresp", 32'(rd_resp), 32'd0);

        // Reset while in WR_RESP with CFG0 nonzero.
        @(negedge ap_clk);
        awvalid = 1'b1; awaddr = 12'h010;
        @(negedge ap_clk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        @(negedge ap_clk);
        wvalid = 1'b0;
        check("pre_rst_bvalid", 32'(bvalid), 32'd1);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_wstate", 32'(dut.inst_control_s_axi.wstate), 32'd3);
        ap_rst_n = 1'b1;
        repeat (3) @(negedge ap_clk);
        axi_read(12'h010, rd_val, rd_resp);
        check("post_rst_cfg0", rd_val, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/ali_dmod.md
ALI_DMOD -- requirements
Module: ali_dmod

Interface
REQ-001 The block SHALL have parameter C_S_AXI_CONTROL_ADDR_WIDTH, default 12, AXI-Lite address width.
REQ-002 The block SHALL have parameter C_S_AXI_CONTROL_DATA_WIDTH, default 32, AXI-Lite data width; only 32 is supported.
REQ-003 The block SHALL have parameters C_OUT_TDATA_WIDTH (64), C_IN_TDATA_WIDTH (64) and C_TUSER_WIDTH (8), reserved for stream ports and unused in this revision.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 ap_clk  in  1  clock; all logic on the rising edge.
REQ-006 ap_rst_n  in  1  synchronous active-low reset.
REQ-007 s_axi_control_awvalid/awready  in/out  1/1  write-address handshake; s_axi_control_awaddr  in  ADDR_WIDTH  write byte address.
REQ-008 s_axi_control_wvalid/wready  in/out  1/1  write-data handshake; s_axi_control_wdata  in  32  write data; s_axi_control_wstrb  in  4  byte enables.
REQ-009 s_axi_control_bvalid/bready  out/in  1/1  write-response handshake; s_axi_control_bresp  out  2  write response.
REQ-010 s_axi_control_arvalid/arready  in/out  1/1  read-address handshake; s_axi_control_araddr  in  ADDR_WIDTH  read byte address.
REQ-011 s_axi_control_rvalid/rready  out/in  1/1  read-data handshake; s_axi_control_rdata  out  32  read data; s_axi_control_rresp  out  2  read response.
REQ-012 The AXI-Lite slave logic SHALL live in a submodule instance named inst_control_s_axi, which exposes a 2-bit register named wstate.

Function
REQ-013 Register map, decoded on addr[11:2] with addr[1:0] ignored:
- 0x000 ID: RO, constant 32'hA11D_0D01.
- 0x010, 0x014, 0x018, 0x01C CFG0..CFG3: RW, reset value 0.
REQ-014 Reads of unmapped addresses SHALL return 0, writes to unmapped or RO addresses SHALL be ignored, and bresp and rresp SHALL always be 2'b00 (OKAY).
REQ-015 The write FSM (wstate) SHALL have the encodings WR_IDLE=0, WR_DATA=1, WR_RESP=2 and WR_RST=3.
REQ-016 In WR_RST, awready=0, wready=0 and bvalid=0; the FSM SHALL move to WR_IDLE on the first clock with ap_rst_n=1.
REQ-017 In WR_IDLE, awready=1; an awvalid&awready cycle SHALL register awaddr and move the FSM to WR_DATA.
REQ-018 In WR_DATA, wready=1 and awready=0; a wvalid&wready cycle SHALL update the addressed register bytewise per wstrb and move the FSM to WR_RESP.
REQ-019 The register update from REQ-018 SHALL be visible to a read issued on the following cycle.
REQ-020 In WR_RESP, bvalid=1 and bresp=00; the FSM SHALL hold until bready, then return to WR_IDLE on the handshake cycle.
REQ-021 W SHALL never be accepted before AW; a wvalid asserted together with awvalid in WR_IDLE SHALL wait until the FSM reaches WR_DATA.
REQ-022 The read FSM SHALL have two states: RD_IDLE and RD_DATA.
REQ-023 In RD_IDLE, arready=1 (after reset); an arvalid&arready cycle SHALL register the decoded register value into rdata and move the FSM to RD_DATA.
REQ-024 In RD_DATA, rvalid=1 and arready=0; the FSM SHALL hold until rready, then return to RD_IDLE.
REQ-025 rdata SHALL hold its last value after the R handshake until the next accepted read address.
REQ-026 Read and write FSMs SHALL be independent, so a read and a write may be in flight concurrently.
REQ-027 If a write and a read target the same register in the same cycle, the read SHALL return the pre-write value.
REQ-028 All valid/ready outputs SHALL be driven directly from registers or state decode, with no combinational path from any input valid to an output ready.

Reset
REQ-029 While ap_rst_n=0, at each clock edge:
- wstate=WR_RST and the read FSM is in RD_IDLE with arready=0;
- awready, wready, bvalid, rvalid = 0;
- bresp, rresp, rdata = 0;
- CFG0..CFG3 = 0.
REQ-030 A reset asserted mid-transaction SHALL abort the transaction, discard any pending write and drop bvalid/rvalid on the next edge.
REQ-031 In the first cycle after reset release, awready and arready SHALL be 0, and both SHALL be 1 from the second cycle onward.

Verification
REQ-032 Hold reset for 2 us, release, wait 1 us; then write 0x0000_0010 <= 0x1234_5678 with wstrb=F, AW then W -> bresp=00; read 0x010 -> rresp=00 and rdata=0x1234_5678, still valid after rready drops.
REQ-033 Read 0x000 -> 0xA11D_0D01; write 0xFFFF_FFFF to 0x000 and read again -> still 0xA11D_0D01.
REQ-034 Write 0x014 <= 0xAABBCCDD with wstrb=F, then write 0x014 <= 0x11223344 with wstrb=0101b -> read 0x014 returns 0xAA22CC44.
REQ-035 Hold bready=0 for 5 cycles after W -> bvalid stays 1 and wstate=WR_RESP; assert bready -> wstate=WR_IDLE on the next cycle.
REQ-036 Assert reset while in WR_RESP with CFG0 nonzero -> bvalid=0, wstate=WR_RST, and after release read 0x010 returns 0.
REQ-037 Read unmapped 0x100 -> rdata=0 and rresp=00.
